// File: rtl/c157x_track_sched_pkg.sv
// c157x track scheduler: shared types and constants.
// Optional ack timeout is enabled by C157X_SCHED_ACK_TIMEOUT_EN.
package c157x_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FLUSH_REQ,
        FLUSH_ACK,
        LOAD_REQ,
        LOAD_ACK,
        READY
    } state_t;

    typedef logic [7:0] track_t;

    localparam track_t     NO_TRACK      = 8'hFF;
    localparam logic [6:0] MAX_HALFTRACK = 7'd83;

    function automatic logic [6:0] clamp_ht(input logic [6:0] t);
        return (t > MAX_HALFTRACK) ? MAX_HALFTRACK : t;
    endfunction

endpackage

// File: rtl/c157x_track_sched_if.sv
// c157x track scheduler: SD host track-transfer bus.
// master = scheduler, slave = SD host.
interface c157x_track_sched_if;
    import c157x_sched_pkg::*;

    logic       sd_rd;
    logic       sd_wr;
    logic       sd_ack;
    track_t     sd_track;
    logic [1:0] sd_drive;

    modport master (
        output sd_rd, sd_wr, sd_track, sd_drive,
        input  sd_ack
    );

    modport slave (
        input  sd_rd, sd_wr, sd_track, sd_drive,
        output sd_ack
    );

endinterface

// File: rtl/c157x_settle_timer.sv
// c157x track scheduler: reloadable down-counter.
// done_o is high while running with the count at zero.
module c157x_settle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         run_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (run_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/c157x_track_sched.sv
// c157x track scheduler: settles on a requested track, flushes/loads it.
// Build with C157X_SCHED_ACK_TIMEOUT_EN for the sticky ack timeout.
module c157x_track_sched
    import c157x_sched_pkg::*;
#(
    parameter int DRIVE         = 0,
    parameter int SETTLE_CYCLES = 24000,
    parameter int TIMEOUT_LOG2  = 22
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 img_mounted,
    input  logic                 img_readonly,
    input  logic                 motor,
    input  logic [6:0]           req_track,
    input  logic                 req_side,
    input  logic                 sd_update,
    output logic                 sd_busy,
    c157x_track_sched_if.master  sd,
    output track_t               cur_track,
    output logic                 dirty,
    output logic                 error
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);

    state_t state_q, state_d, ret_q, ret_d;
    track_t tgt_q, tgt_d, cur_q, cur_d, trk_q, trk_d;
    logic   dirty_q, dirty_d, fonly_q, fonly_d;
    logic   mpend_q, mpend_d, err_q, err_d, motor_q;
    logic   st_load, st_done, chg, ack_ph, fin, to_done;

    assign tgt_d  = {req_side, clamp_ht(req_track)};
    assign chg    = tgt_d != tgt_q;
    assign ack_ph = (state_q == FLUSH_ACK) || (state_q == LOAD_ACK);

    c157x_settle_timer #(.W(SW)) u_settle (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (st_load),
        .val_i   (SETTLE_RELOAD),
        .run_i   (state_q == SETTLE),
        .done_o  (st_done)
    );

`ifdef C157X_SCHED_ACK_TIMEOUT_EN
    logic xfer, to_load;
    assign xfer    = (state_q == FLUSH_REQ) || (state_q == LOAD_REQ) || ack_ph;
    assign to_load = !xfer || (state_d != state_q);

    c157x_settle_timer #(.W(TIMEOUT_LOG2)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (to_load),
        .val_i   ({TIMEOUT_LOG2{1'b1}}),
        .run_i   (xfer),
        .done_o  (to_done)
    );
`else
    logic [31:0] unused_to;
    assign unused_to = 32'(TIMEOUT_LOG2);
    assign to_done   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            tgt_q   <= NO_TRACK;
            cur_q   <= NO_TRACK;
            trk_q   <= '0;
            dirty_q <= 1'b0;
            fonly_q <= 1'b0;
            mpend_q <= 1'b0;
            err_q   <= 1'b0;
            motor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            trk_q   <= trk_d;
            dirty_q <= dirty_d;
            fonly_q <= fonly_d;
            mpend_q <= mpend_d;
            err_q   <= err_d;
            motor_q <= motor;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cur_d   = cur_q;
        trk_d   = trk_q;
        dirty_d = dirty_q;
        fonly_d = fonly_q;
        mpend_d = mpend_q;
        err_d   = err_q;
        st_load = 1'b0;
        fin     = 1'b0;
        if (!ack_ph && !enable) begin
            state_d = IDLE;
            cur_d   = NO_TRACK;
            fonly_d = 1'b0;
        end else if (!ack_ph && img_mounted) begin
            state_d = SETTLE;
            ret_d   = IDLE;
            cur_d   = NO_TRACK;
            dirty_d = 1'b0;
            fonly_d = 1'b0;
            err_d   = 1'b0;
            st_load = 1'b1;
        end else begin
            if (img_mounted) mpend_d = 1'b1;
            unique case (state_q)
                IDLE, READY: begin
                    if (motor && tgt_q != cur_q) begin
                        state_d = SETTLE;
                        ret_d   = state_q;
                        st_load = 1'b1;
                    end else if (state_q == READY && motor_q
                                 && !motor && dirty_q) begin
                        state_d = FLUSH_REQ;
                        trk_d   = cur_q;
                        fonly_d = 1'b1;
                    end
                    if (state_q == READY && sd_update && !img_readonly)
                        dirty_d = 1'b1;
                end
                SETTLE: begin
                    if (!motor) begin
                        state_d = ret_q;
                    end else if (chg) begin
                        st_load = 1'b1;
                    end else if (st_done) begin
                        // a dirty flag with no valid track has nothing to save
                        if (dirty_q && cur_q != NO_TRACK) begin
                            state_d = FLUSH_REQ;
                            trk_d   = cur_q;
                        end else begin
                            state_d = LOAD_REQ;
                            trk_d   = tgt_q;
                        end
                    end
                end
                FLUSH_REQ: if (sd.sd_ack) state_d = FLUSH_ACK;
                FLUSH_ACK: begin
                    if (!sd.sd_ack) begin
                        dirty_d = 1'b0;
                        fonly_d = 1'b0;
                        fin     = 1'b1;
                        if (!fonly_q && tgt_q != cur_q) begin
                            state_d = LOAD_REQ;
                            trk_d   = tgt_q;
                        end else begin
                            state_d = READY;
                        end
                    end
                end
                LOAD_REQ: if (sd.sd_ack) state_d = LOAD_ACK;
                LOAD_ACK: begin
                    if (!sd.sd_ack) begin
                        cur_d   = trk_q;
                        state_d = READY;
                        fin     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // deferred mount/disable take effect once the ack has fallen
            if (fin) begin
                mpend_d = 1'b0;
                if (mpend_q || img_mounted) begin
                    state_d = SETTLE;
                    ret_d   = IDLE;
                    cur_d   = NO_TRACK;
                    dirty_d = 1'b0;
                    err_d   = 1'b0;
                    st_load = 1'b1;
                end
                if (!enable) begin
                    state_d = IDLE;
                    cur_d   = NO_TRACK;
                end
            end
            if (to_done) begin
                state_d = IDLE;
                cur_d   = NO_TRACK;
                err_d   = 1'b1;
                mpend_d = 1'b0;
                fonly_d = 1'b0;
            end
        end
    end

    assign sd.sd_rd    = (state_q == LOAD_REQ);
    assign sd.sd_wr    = (state_q == FLUSH_REQ);
    assign sd.sd_track = trk_q;
    assign sd.sd_drive = 2'(DRIVE);
    assign sd_busy     = (state_q == FLUSH_REQ) || (state_q == LOAD_REQ)
                         || ack_ph;
    assign cur_track   = cur_q;
    assign dirty       = dirty_q;
    assign error       = err_q;

endmodule

// File: tb/tb_c157x_track_sched.sv
// c157x track scheduler bench: SD host model plus transfer scoreboard.
// Covers settle, flush/load ordering, readonly, mount and enable handling.
module tb_c157x_track_sched;

    localparam int N = 20;

    logic       clk = 1'b0;
    logic       reset_n, enable, img_mounted, img_readonly, motor;
    logic [6:0] req_track;
    logic       req_side, sd_update;
    logic       sd_busy, dirty, error;
    logic [7:0] cur_track;
    logic       host_en;
    int         checks = 0;
    int         errors = 0;
    int         req_cnt = 0;
    int         hdly = 0;
    int         hcnt = 0;
    logic [8:0] sb_q[$];

    c157x_track_sched_if sd_if();

    c157x_track_sched #(
        .DRIVE         (1),
        .SETTLE_CYCLES (N),
        .TIMEOUT_LOG2  (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .motor        (motor),
        .req_track    (req_track),
        .req_side     (req_side),
        .sd_update    (sd_update),
        .sd_busy      (sd_busy),
        .sd           (sd_if.master),
        .cur_track    (cur_track),
        .dirty        (dirty),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // SD host: ack two cycles after a request, hold it ten cycles
    initial begin
        sd_if.sd_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sd_if.sd_ack) begin
                if (hcnt == 0) sd_if.sd_ack = 1'b0;
                else hcnt--;
            end else if ((sd_if.sd_rd || sd_if.sd_wr) && host_en) begin
                if (hdly == 2) begin
                    sd_if.sd_ack = 1'b1;
                    hcnt = 9;
                    hdly = 0;
                end else begin
                    hdly++;
                end
            end
        end
    end

    // scoreboard: every request rise pops one expected {wr, track}
    initial begin
        logic prev = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if ((sd_if.sd_rd || sd_if.sd_wr) && !prev) begin
                req_cnt++;
                chk("rdwr_excl", 32'(sd_if.sd_rd & sd_if.sd_wr), 0);
                chk("sb_avail", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("req_kind", 32'(sd_if.sd_wr), 32'(e[8]));
                    chk("req_track", 32'(sd_if.sd_track), 32'(e[7:0]));
                end
            end
            prev = sd_if.sd_rd || sd_if.sd_wr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_cur(input string tag, input logic [7:0] t);
        int n = 0;
        @(negedge clk);
        while (!(cur_track == t && !sd_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cur_track), 32'(t));
    endtask

    task automatic wait_busy(input string tag, input logic v);
        int n = 0;
        while (sd_busy !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sd_busy), 32'(v));
    endtask

    task automatic pulse_update();
        sd_update = 1'b1;
        @(negedge clk);
        sd_update = 1'b0;
    endtask

    initial begin
        int lat, c0;
        reset_n = 1'b0; enable = 1'b1; img_mounted = 1'b0;
        img_readonly = 1'b0; motor = 1'b0; req_track = 7'd0;
        req_side = 1'b0; sd_update = 1'b0; host_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(sd_busy), 0);
        chk("rst_rd", 32'(sd_if.sd_rd), 0);
        chk("rst_wr", 32'(sd_if.sd_wr), 0);
        chk("rst_trk", 32'(sd_if.sd_track), 0);
        chk("rst_cur", 32'(cur_track), 32'h0FF);
        chk("rst_dirty", 32'(dirty), 0);
        chk("rst_err", 32'(error), 0);
        chk("drive", 32'(sd_if.sd_drive), 1);
        reset_n = 1'b1;
        @(negedge clk);

        // first load of half-track 36
        sb_q.push_back({1'b0, 8'h24});
        motor = 1'b1; req_track = 7'd36;
        lat = 0;
        while (!sd_if.sd_rd && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("settle_lat", 32'(lat >= N && lat <= N + 2), 1);
        wait (sd_if.sd_ack === 1'b1);
        @(negedge clk);
        while (sd_if.sd_ack && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_hold", 32'(sd_busy), 1);
        @(negedge clk);
        chk("busy_fall", 32'(sd_busy), 0);
        chk("cur36", 32'(cur_track), 32'h24);

        // dirty track is written back before the next load
        pulse_update();
        chk("dirty_set", 32'(dirty), 1);
        sb_q.push_back({1'b1, 8'h24});
        sb_q.push_back({1'b0, 8'h26});
        req_track = 7'd38;
        lat = 0;
        while (!sd_if.sd_rd && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("dirty_clr", 32'(dirty), 0);
        wait_cur("cur38", 8'h26);

        // toggling request never settles
        c0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            req_track = (i % 2 == 0) ? 7'd36 : 7'd37;
            repeat (N / 2) @(negedge clk);
        end
        chk("toggle_quiet", 32'(req_cnt - c0), 0);
        sb_q.push_back({1'b0, 8'h25});
        req_track = 7'd37;
        wait_cur("cur37", 8'h25);
        chk("one_rd", 32'(req_cnt - c0), 1);

        // side 1, out-of-range half-track clamps to 83
        sb_q.push_back({1'b0, 8'hD3});
        req_side = 1'b1; req_track = 7'd100;
        wait_cur("clamp", 8'hD3);

        // readonly image: updates ignored, motor off writes nothing
        img_readonly = 1'b1;
        repeat (3) pulse_update();
        chk("ro_dirty", 32'(dirty), 0);
        c0 = req_cnt;
        motor = 1'b0;
        repeat (2 * N) @(negedge clk);
        chk("ro_nowr", 32'(req_cnt - c0), 0);
        img_readonly = 1'b0;

        // motor falling with a dirty buffer flushes in place
        motor = 1'b1;
        repeat (3) @(negedge clk);
        pulse_update();
        chk("mf_dirty", 32'(dirty), 1);
        sb_q.push_back({1'b1, 8'hD3});
        motor = 1'b0;
        wait_busy("mf_busy", 1'b1);
        wait_cur("mf_cur", 8'hD3);
        chk("mf_clean", 32'(dirty), 0);
        chk("mf_only_wr", 32'(req_cnt - c0), 1);

        // mount during the load ack: finish, invalidate, reload
        sb_q.push_back({1'b0, 8'h24});
        sb_q.push_back({1'b0, 8'h24});
        req_side = 1'b0; req_track = 7'd36; motor = 1'b1;
        lat = 0;
        while (!(sd_if.sd_ack && !sd_if.sd_rd && sd_busy) && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
        wait_busy("mnt_done", 1'b0);
        chk("mnt_cur", 32'(cur_track), 32'h0FF);
        chk("mnt_dirty", 32'(dirty), 0);
        wait_cur("mnt_reload", 8'h24);

        // enable low drops to IDLE, re-enable reloads
        enable = 1'b0;
        @(negedge clk);
        chk("dis_cur", 32'(cur_track), 32'h0FF);
        chk("dis_busy", 32'(sd_busy), 0);
        sb_q.push_back({1'b0, 8'h24});
        enable = 1'b1;
        wait_busy("en_busy", 1'b1);
        wait_cur("en_reload", 8'h24);

`ifdef C157X_SCHED_ACK_TIMEOUT_EN
        // unanswered request times out after 256 cycles
        host_en = 1'b0;
        sb_q.push_back({1'b0, 8'h28});
        req_track = 7'd40;
        lat = 0;
        while (!sd_if.sd_rd && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        lat = 0;
        while (sd_if.sd_rd && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        motor = 1'b0;
        chk("to_len", 32'(lat), 256);
        chk("to_err", 32'(error), 1);
        chk("to_cur", 32'(cur_track), 32'h0FF);
        chk("to_busy", 32'(sd_busy), 0);
        host_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
